// File: rtl/program_loader_arbiter.sv
// Boot-time owner of the program memory: assembles a big-endian byte stream into
// 32-bit words, writes them from word 0 upward, then hands the read port to the CPU.
module program_loader_arbiter #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_load,
  input  logic [ADDR_WIDTH:0]   load_words,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic [DATA_WIDTH-1:0] cpu_pc,
  output logic                  cpu_stall,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  addr_fault,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  load_done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [ADDR_WIDTH:0]   LP_DEPTH   = (ADDR_WIDTH+1)'(MEMORY_DEPTH);
  localparam logic [DATA_WIDTH-3:0] LP_DEPTH_W = (DATA_WIDTH-2)'(MEMORY_DEPTH);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH:0]   r_target;
  logic [ADDR_WIDTH:0]   r_word_ptr;
  logic [1:0]            r_byte_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_load_done;

  logic                  w_accept;
  logic                  w_word_done;
  logic                  w_last_word;
  logic                  w_restart;
  logic                  w_fault;
  logic [ADDR_WIDTH:0]   w_target_new;
  logic [DATA_WIDTH-1:0] w_word;

  function automatic logic [ADDR_WIDTH:0] sat_target(input logic [ADDR_WIDTH:0] n);
    return (n > LP_DEPTH) ? LP_DEPTH : n;
  endfunction

  assign w_accept     = (r_state == LOAD) && byte_valid;
  assign w_word_done  = w_accept && (r_byte_cnt == 2'd3);
  assign w_last_word  = w_word_done && ((r_word_ptr + 1'b1) == r_target);
  assign w_restart    = start_load && (r_state != LOAD);
  assign w_target_new = sat_target(load_words);
  assign w_word       = {r_shift[DATA_WIDTH-9:0], byte_data};
  assign w_fault      = (cpu_pc[1:0] != 2'b00) || (cpu_pc[DATA_WIDTH-1:2] >= LP_DEPTH_W);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, RUN: if (start_load) w_state_nxt = (w_target_new == '0) ? RUN : LOAD;
      LOAD:      if (w_last_word) w_state_nxt = RUN;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_stall   = 1'b1;
    byte_ready  = 1'b0;
    instruction = '0;
    addr_fault  = 1'b0;
    mem_raddr   = '0;
    case (r_state)
      LOAD: byte_ready = 1'b1;
      RUN: begin
        cpu_stall   = 1'b0;
        mem_raddr   = cpu_pc[ADDR_WIDTH+1:2];
        addr_fault  = w_fault;
        instruction = w_fault ? '0 : mem_rdata;
      end
      default: ;
    endcase
  end

  // Assembly stage: byte shift, word pointer and the registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_target    <= '0;
      r_word_ptr  <= '0;
      r_byte_cnt  <= '0;
      r_shift     <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= 1'b0;
      if (w_restart) begin
        r_target    <= w_target_new;
        r_word_ptr  <= '0;
        r_byte_cnt  <= '0;
        r_load_done <= (w_target_new == '0);
      end
      if (w_accept) begin
        r_shift    <= w_word;
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (w_word_done) begin
          r_we       <= 1'b1;
          r_waddr    <= r_word_ptr[ADDR_WIDTH-1:0];
          r_wdata    <= w_word;
          r_word_ptr <= r_word_ptr + 1'b1;
          if (w_last_word) r_load_done <= 1'b1;
        end
      end
    end
  end

  assign mem_we    = r_we;
  assign mem_waddr = r_waddr;
  assign mem_wdata = r_wdata;
  assign load_done = r_load_done;

endmodule
